// File: rtl/synaptic_update_engine.sv
// Synaptic update engine: per fired source tag, sweeps every destination and adds the weight to i_next.
// Build option: define SYNAPSE_SATURATE_EN to clamp sums on overflow and flag ovf; otherwise sums wrap.
module synaptic_update_engine #(
  parameter int unsigned NUMNEURONS = 2,
  parameter int unsigned NUMWIDTH   = 16,
  parameter int unsigned TAGBITS    = 1
) (
  input  logic                clk,
  input  logic                asyn_reset_n,
  input  logic                fifo_empty,
  input  logic [TAGBITS-1:0]  src_tag_in,
  input  logic                halt,
  output logic                req_deq,
  output logic                rd_en,
  output logic [TAGBITS-1:0]  rd_src_tag,
  output logic [TAGBITS-1:0]  rd_dst_tag,
  input  logic [NUMWIDTH:0]   weight_in,
  input  logic [NUMWIDTH:0]   i_next_in,
  output logic                wr_en,
  output logic [TAGBITS-1:0]  wr_dst_tag,
  output logic [NUMWIDTH:0]   i_next_out,
  output logic                ovf,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DW = NUMWIDTH + 1;
  localparam int unsigned SW = NUMWIDTH + 2;
  localparam logic [TAGBITS-1:0] LAST_DST = TAGBITS'(NUMNEURONS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEQ   = 3'd1,
    READ  = 3'd2,
    ACCUM = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t               r_state;
  logic [TAGBITS-1:0]   r_src;
  logic [TAGBITS-1:0]   r_dst;

  state_t               w_state_nxt;
  logic [TAGBITS-1:0]   w_src_nxt;
  logic [TAGBITS-1:0]   w_dst_nxt;
  logic                 w_req_deq_nxt;
  logic                 w_rd_en_nxt;
  logic [TAGBITS-1:0]   w_rd_src_nxt;
  logic [TAGBITS-1:0]   w_rd_dst_nxt;
  logic                 w_wr_en_nxt;
  logic [TAGBITS-1:0]   w_wr_dst_nxt;
  logic [DW-1:0]        w_result_nxt;
  logic                 w_ovf_nxt;
  logic                 w_done_nxt;
  logic                 w_busy_nxt;

  logic [SW-1:0]        w_sum;
  logic [DW-1:0]        w_sat;
  logic                 w_sat_ovf;

  // Sign-extended add; the two top bits disagree exactly when the sum leaves the DW-bit range.
  always_comb begin
    w_sum     = {i_next_in[NUMWIDTH], i_next_in} + {weight_in[NUMWIDTH], weight_in};
    w_sat     = w_sum[DW-1:0];
    w_sat_ovf = 1'b0;
`ifdef SYNAPSE_SATURATE_EN
    w_sat_ovf = w_sum[SW-1] ^ w_sum[SW-2];
    if (w_sat_ovf) begin
      w_sat = w_sum[SW-1] ? {1'b1, {NUMWIDTH{1'b0}}} : {1'b0, {NUMWIDTH{1'b1}}};
    end
`endif
  end

  // Next state and next value of every registered output.
  always_comb begin
    w_state_nxt   = r_state;
    w_src_nxt     = r_src;
    w_dst_nxt     = r_dst;
    w_req_deq_nxt = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_rd_src_nxt  = rd_src_tag;
    w_rd_dst_nxt  = rd_dst_tag;
    w_wr_en_nxt   = 1'b0;
    w_wr_dst_nxt  = wr_dst_tag;
    w_result_nxt  = i_next_out;
    w_ovf_nxt     = 1'b0;
    w_done_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        if (!fifo_empty && !halt) begin
          w_state_nxt   = DEQ;
          w_req_deq_nxt = 1'b1;
        end
      end
      DEQ: begin
        w_src_nxt    = src_tag_in;
        w_dst_nxt    = '0;
        w_state_nxt  = READ;
        w_rd_en_nxt  = 1'b1;
        w_rd_src_nxt = src_tag_in;
        w_rd_dst_nxt = '0;
      end
      READ: begin
        w_state_nxt = ACCUM;
      end
      ACCUM: begin
        w_state_nxt  = WRITE;
        w_wr_en_nxt  = 1'b1;
        w_wr_dst_nxt = r_dst;
        w_result_nxt = w_sat;
        w_ovf_nxt    = w_sat_ovf;
        w_done_nxt   = (r_dst == LAST_DST);
      end
      WRITE: begin
        if (r_dst == LAST_DST) begin
          w_state_nxt = IDLE;
        end else begin
          w_dst_nxt    = r_dst + TAGBITS'(1);
          w_state_nxt  = READ;
          w_rd_en_nxt  = 1'b1;
          w_rd_src_nxt = r_src;
          w_rd_dst_nxt = r_dst + TAGBITS'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      r_state    <= IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      req_deq    <= 1'b0;
      rd_en      <= 1'b0;
      rd_src_tag <= '0;
      rd_dst_tag <= '0;
      wr_en      <= 1'b0;
      wr_dst_tag <= '0;
      i_next_out <= '0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_dst      <= w_dst_nxt;
      req_deq    <= w_req_deq_nxt;
      rd_en      <= w_rd_en_nxt;
      rd_src_tag <= w_rd_src_nxt;
      rd_dst_tag <= w_rd_dst_nxt;
      wr_en      <= w_wr_en_nxt;
      wr_dst_tag <= w_wr_dst_nxt;
      i_next_out <= w_result_nxt;
      ovf        <= w_ovf_nxt;
      busy       <= w_busy_nxt;
      done       <= w_done_nxt;
    end
  end

endmodule
